// File: rtl/ntr_xfer_sequencer_if.sv
// Cart-bus / decoder / data-source bundle for ntr_xfer_sequencer.
//   slave  : the sequencer side (captures command, drives response)
//   master : the environment side (bus pins, decoder, data source)
// Signals: cs1/bus_en/din (bus in), cmd_out/cmd_valid/cmd_ack/rsp_len
// (decoder handshake), rd_valid/rd_data/rd_pop (data source),
// dout/dout_oe/busy/xfer_done/xfer_abort/underrun (status and bus out).
interface ntr_xfer_sequencer_if #(
  parameter int unsigned LEN_W = 13
);
  logic             cs1;
  logic             bus_en;
  logic [7:0]       din;
  logic [63:0]      cmd_out;
  logic             cmd_valid;
  logic             cmd_ack;
  logic [LEN_W-1:0] rsp_len;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_pop;
  logic [7:0]       dout;
  logic             dout_oe;
  logic             busy;
  logic             xfer_done;
  logic             xfer_abort;
  logic             underrun;

  modport slave (
    input  cs1, bus_en, din, cmd_ack, rsp_len, rd_valid, rd_data,
    output cmd_out, cmd_valid, rd_pop, dout, dout_oe, busy,
           xfer_done, xfer_abort, underrun
  );

  modport master (
    output cs1, bus_en, din, cmd_ack, rsp_len, rd_valid, rd_data,
    input  cmd_out, cmd_valid, rd_pop, dout, dout_oe, busy,
           xfer_done, xfer_abort, underrun
  );
endinterface

// File: rtl/ntr_xfer_sequencer.sv
// ntr_xfer_sequencer: sequences one NTR cartridge bus transaction.
// Captures the 8-byte command while cs1 is low, offers it to the decoder
// with cmd_valid/cmd_ack, then streams rsp_len (clamped to MAX_LEN) bytes
// from the data source, substituting FILL_BYTE when no data is available.
// Ports: clk, rst (sync, active high), bus (ntr_xfer_sequencer_if.slave),
//        ack_timeout (only when NTR_SEQ_TIMEOUT_EN is defined).
// Optional feature macro NTR_SEQ_TIMEOUT_EN: abandons WAIT_ACK after
// TIMEOUT_CYCLES cycles without cmd_ack and flags sticky ack_timeout.
module ntr_xfer_sequencer #(
  parameter int unsigned CMD_BYTES      = 8,
  parameter int unsigned LEN_W          = 13,
  parameter int unsigned MAX_LEN        = 4096,
  parameter logic [7:0]  FILL_BYTE      = 8'hFF
`ifdef NTR_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  ntr_xfer_sequencer_if.slave bus
`ifdef NTR_SEQ_TIMEOUT_EN
  ,
  output logic                ack_timeout
`endif
);

  localparam int unsigned CNT_W = $clog2(CMD_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT_ACK, S_DATA, S_DONE} state_t;

  state_t           state, state_nx;
  logic             slot;
  logic [CNT_W-1:0] byte_cnt;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rsp_clamped;
  logic [63:0]      cmd_q;
  logic             cmd_valid_q, dout_oe_q, done_q, abort_q, underrun_q;
  logic [7:0]       dout_q;

  logic do_shift, cnt_first, ld_rem, dec_rem, drv_fill, drv_data;
  logic set_ur, clr_ur, done_p, abort_p, set_cv, clr_cv;

`ifdef NTR_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit, set_tmo, tmo_q;
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign ack_timeout = tmo_q;
`endif

  assign slot        = bus.bus_en && !bus.cs1;
  assign rsp_clamped = (bus.rsp_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.rsp_len;

  always_comb begin
    state_nx  = state;
    do_shift  = 1'b0;
    cnt_first = 1'b0;
    ld_rem    = 1'b0;
    dec_rem   = 1'b0;
    drv_fill  = 1'b0;
    drv_data  = 1'b0;
    set_ur    = 1'b0;
    clr_ur    = 1'b0;
    done_p    = 1'b0;
    abort_p   = 1'b0;
    set_cv    = 1'b0;
    clr_cv    = 1'b0;
`ifdef NTR_SEQ_TIMEOUT_EN
    set_tmo   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (slot) begin
          do_shift  = 1'b1;
          cnt_first = 1'b1;
          clr_ur    = 1'b1;
          state_nx  = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.cs1) begin
          abort_p  = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.bus_en) begin
          do_shift = 1'b1;
          if (byte_cnt == CNT_W'(CMD_BYTES - 1)) begin
            set_cv   = 1'b1;
            state_nx = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (bus.cs1) begin
          abort_p  = 1'b1;
          clr_cv   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          drv_fill = bus.bus_en;
          if (bus.cmd_ack) begin
            clr_cv = 1'b1;
            ld_rem = 1'b1;
            if (rsp_clamped == '0) begin
              done_p   = 1'b1;
              state_nx = S_DONE;
            end else begin
              state_nx = S_DATA;
            end
          end
`ifdef NTR_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            clr_cv   = 1'b1;
            done_p   = 1'b1;
            set_tmo  = 1'b1;
            state_nx = S_DONE;
          end
`endif
        end
      end
      S_DATA: begin
        if (bus.cs1) begin
          abort_p  = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.bus_en) begin
          drv_data = 1'b1;
          dec_rem  = 1'b1;
          set_ur   = !bus.rd_valid;
          if (remaining == LEN_W'(1)) begin
            done_p   = 1'b1;
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.cs1) state_nx = S_IDLE;
        else         drv_fill = bus.bus_en;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      byte_cnt    <= '0;
      remaining   <= '0;
      dout_q      <= '0;
      dout_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      done_q    <= done_p;
      abort_q   <= abort_p;
      dout_oe_q <= (state_nx == S_WAIT_ACK) || (state_nx == S_DATA) || (state_nx == S_DONE);
      if (do_shift) begin
        cmd_q    <= {bus.din, cmd_q[63:8]};
        byte_cnt <= cnt_first ? CNT_W'(1) : byte_cnt + CNT_W'(1);
      end
      if (set_cv)      cmd_valid_q <= 1'b1;
      else if (clr_cv) cmd_valid_q <= 1'b0;
      // remaining saturates at zero rather than wrapping
      if (ld_rem)                          remaining <= rsp_clamped;
      else if (dec_rem && remaining != '0) remaining <= remaining - LEN_W'(1);
      if (drv_fill)      dout_q <= FILL_BYTE;
      else if (drv_data) dout_q <= bus.rd_valid ? bus.rd_data : FILL_BYTE;
      if (clr_ur)      underrun_q <= 1'b0;
      else if (set_ur) underrun_q <= 1'b1;
    end
  end

`ifdef NTR_SEQ_TIMEOUT_EN
  // counter is zero on the first WAIT_ACK cycle because it clears in every other state
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == S_WAIT_ACK) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                     tmo_cnt <= '0;
      if (cnt_first)    tmo_q <= 1'b0;
      else if (set_tmo) tmo_q <= 1'b1;
    end
  end
`endif

  assign bus.cmd_out    = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.rd_pop     = (state == S_DATA) && slot && bus.rd_valid;
  assign bus.dout       = dout_q;
  assign bus.dout_oe    = dout_oe_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.xfer_done  = done_q;
  assign bus.xfer_abort = abort_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_ntr_xfer_sequencer.sv
// Testbench for ntr_xfer_sequencer: randomized transactions with a
// scoreboard. Stimulus pushes expected response bytes, commands and
// end-of-transaction events; a negedge monitor pops and compares them.
module tb_ntr_xfer_sequencer;
  localparam int LEN_W = 13;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntr_xfer_sequencer_if #(.LEN_W(LEN_W)) bus_if ();
`ifdef NTR_SEQ_TIMEOUT_EN
  logic ack_timeout;
`endif

  ntr_xfer_sequencer #(
    .CMD_BYTES(8),
    .LEN_W(LEN_W),
    .MAX_LEN(4096),
    .FILL_BYTE(8'hFF)
`ifdef NTR_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef NTR_SEQ_TIMEOUT_EN
    ,
    .ack_timeout(ack_timeout)
`endif
  );

  typedef struct {
    int          kind;   // 1 = done, 2 = abort
    int          cyc;
    bit          ur;
    int          pops;
    logic [63:0] cmd;
    bit          tmo;
  } evt_t;

  typedef struct {
    logic [63:0] cmd;
    int          cyc;
  } cmd_t;

  evt_t       evq[$];
  cmd_t       cmdq[$];
  logic [7:0] byteq[$];
  logic [7:0] hist[$];
  bit         cur_tmo = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The last eight command bytes ever shifted in, oldest in [7:0].
  function automatic logic [63:0] hist_val();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = hist[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side(input bit allow_ack);
    bus_if.rd_valid = 1'($urandom);
    bus_if.rd_data  = 8'($urandom);
    bus_if.rsp_len  = LEN_W'($urandom);
    bus_if.cmd_ack  = allow_ack ? 1'($urandom) : 1'b0;
    bus_if.din      = 8'($urandom);
  endtask

  // Monitor / scoreboard
  bit   pend = 1'b0;
  bit   cv_q = 1'b0;
  int   pops = 0;
  evt_t me;
  cmd_t mc;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      cv_q = 1'b0;
      pops = 0;
    end else begin
      if (pend) begin
        if (byteq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout_extra: got byte %0h expected none (cycle %0d)", bus_if.dout, cyc);
        end else begin
          chk("dout", bus_if.dout, byteq.pop_front());
        end
      end
      pend = bus_if.bus_en && !bus_if.cs1 && bus_if.dout_oe;
      if (bus_if.rd_pop) pops++;
      if (bus_if.cmd_valid && !cv_q) begin
        if (cmdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_extra: got cmd_valid with %0h expected none (cycle %0d)", bus_if.cmd_out, cyc);
        end else begin
          mc = cmdq.pop_front();
          chk("cmd_out", bus_if.cmd_out, mc.cmd);
          chk("cmd_valid_cyc", 64'(cyc), 64'(mc.cyc));
        end
      end
      cv_q = bus_if.cmd_valid;
      if (bus_if.xfer_done || bus_if.xfer_abort) begin
        if (evq.size() == 0) begin
          checks++; errors++;
          $display("FAIL evt_extra: got done=%0b abort=%0b expected none (cycle %0d)",
                   bus_if.xfer_done, bus_if.xfer_abort, cyc);
        end else begin
          me = evq.pop_front();
          chk("evt_kind", {bus_if.xfer_abort, bus_if.xfer_done}, (me.kind == 1) ? 64'd1 : 64'd2);
          chk("evt_cyc", 64'(cyc), 64'(me.cyc));
          chk("underrun", bus_if.underrun, me.ur);
          chk("rd_pop_cnt", 64'(pops), 64'(me.pops));
          chk("cmd_valid_clr", bus_if.cmd_valid, 64'd0);
          chk("busy_evt", bus_if.busy, (me.kind == 1) ? 64'd1 : 64'd0);
          if (me.kind == 2) chk("cmd_out_partial", bus_if.cmd_out, me.cmd);
`ifdef NTR_SEQ_TIMEOUT_EN
          chk("ack_timeout", ack_timeout, me.tmo);
`endif
        end
        pops = 0;
      end
    end
  end

  // One transaction. abort_idx: -1 none, -2 abort in WAIT_ACK, >=0 abort at that
  // data slot. rst_idx >= 0 resets at that data slot. bad_idx forces rd_valid low.
  task automatic xfer(input int n_cmd, input bit seq, input int len, input int vpct,
                      input int bad_idx, input int abort_idx, input int rst_idx,
                      input bit no_ack);
    int         eff, cnt, npop, k8, wn, dn;
    bit         ur, v;
    logic [7:0] b;
    k8 = 0;
    for (int i = 0; i < n_cmd; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        rand_side(1'b1); bus_if.cs1 = 1'b0; bus_if.bus_en = 1'b0; step();
      end
      rand_side(1'b1);
      bus_if.cs1 = 1'b0; bus_if.bus_en = 1'b1;
      b = seq ? 8'(i) : 8'($urandom);
      bus_if.din = b;
      hist.push_back(b);
      void'(hist.pop_front());
      if (i == 0) cur_tmo = 1'b0;
      if (i == 7) begin
        cmdq.push_back(cmd_t'{hist_val(), cyc + 1});
        k8 = cyc;
      end
      step();
    end
    if (n_cmd < 8) begin
      rand_side(1'b1); bus_if.cs1 = 1'b1; bus_if.bus_en = 1'($urandom);
      evq.push_back(evt_t'{2, cyc + 1, 1'b0, 0, hist_val(), cur_tmo});
      step();
      rand_side(1'b1); bus_if.bus_en = 1'b0; step();
      return;
    end
    eff = 0;
    if (no_ack) begin
`ifdef NTR_SEQ_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
        rand_side(1'b0); bus_if.cs1 = 1'b0; bus_if.bus_en = 1'($urandom);
        if (bus_if.bus_en) byteq.push_back(8'hFF);
        step();
      end
      cur_tmo = 1'b1;
      evq.push_back(evt_t'{1, k8 + 1 + TMO, 1'b0, 0, 64'd0, 1'b1});
`endif
    end else begin
      wn = $urandom_range(0, 5);
      for (int i = 0; i < wn; i++) begin
        rand_side(1'b0); bus_if.cs1 = 1'b0; bus_if.bus_en = 1'($urandom);
        if (bus_if.bus_en) byteq.push_back(8'hFF);
        step();
      end
      if (abort_idx == -2) begin
        rand_side(1'b0); bus_if.cs1 = 1'b1; bus_if.bus_en = 1'($urandom);
        evq.push_back(evt_t'{2, cyc + 1, 1'b0, 0, hist_val(), cur_tmo});
        step();
        rand_side(1'b1); bus_if.bus_en = 1'b0; step();
        return;
      end
      rand_side(1'b0); bus_if.cs1 = 1'b0; bus_if.bus_en = 1'($urandom);
      if (bus_if.bus_en) byteq.push_back(8'hFF);
      bus_if.cmd_ack = 1'b1;
      bus_if.rsp_len = LEN_W'(len);
      eff = (len > 4096) ? 4096 : len;
      if (eff == 0) evq.push_back(evt_t'{1, cyc + 1, 1'b0, 0, 64'd0, cur_tmo});
      step();
    end
    cnt = 0; npop = 0; ur = 1'b0;
    while (cnt < eff) begin
      rand_side(1'b1);
      bus_if.cs1 = 1'b0;
      if (cnt == abort_idx) begin
        bus_if.cs1 = 1'b1; bus_if.bus_en = 1'($urandom);
        evq.push_back(evt_t'{2, cyc + 1, ur, npop, hist_val(), cur_tmo});
        step();
        rand_side(1'b1); bus_if.bus_en = 1'b0; step();
        return;
      end
      if (cnt == rst_idx) begin
        bus_if.bus_en = 1'b0; step();
        rand_side(1'b1); bus_if.bus_en = 1'b0; rst = 1'b1; step();
        chk("rst_outputs",
            {bus_if.cmd_out != 64'd0, bus_if.cmd_valid, bus_if.rd_pop, bus_if.dout != 8'd0,
             bus_if.dout_oe, bus_if.busy, bus_if.xfer_done, bus_if.xfer_abort, bus_if.underrun},
            64'd0);
`ifdef NTR_SEQ_TIMEOUT_EN
        chk("rst_ack_timeout", ack_timeout, 64'd0);
`endif
        rst = 1'b0;
        bus_if.cs1 = 1'b1;
        for (int i = 0; i < 8; i++) hist[i] = 8'h00;
        cur_tmo = 1'b0;
        step();
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus_if.bus_en = 1'b0; step();
        continue;
      end
      bus_if.bus_en = 1'b1;
      v = (cnt == bad_idx) ? 1'b0 : ($urandom_range(1, 100) <= vpct);
      bus_if.rd_valid = v;
      byteq.push_back(v ? bus_if.rd_data : 8'hFF);
      if (v) npop++; else ur = 1'b1;
      cnt++;
      if (cnt == eff) evq.push_back(evt_t'{1, cyc + 1, ur, npop, 64'd0, cur_tmo});
      step();
    end
    dn = $urandom_range(0, 4);
    for (int i = 0; i < dn; i++) begin
      rand_side(1'b1); bus_if.cs1 = 1'b0; bus_if.bus_en = 1'($urandom);
      if (bus_if.bus_en) byteq.push_back(8'hFF);
      step();
    end
    rand_side(1'b1); bus_if.cs1 = 1'b1; bus_if.bus_en = 1'($urandom);
    step();
    chk("busy_after_cs1", bus_if.busy, 64'd0);
    chk("dout_oe_after_cs1", bus_if.dout_oe, 64'd0);
  endtask

  initial begin
    int n, len, r, ab;
    for (int i = 0; i < 8; i++) hist.push_back(8'h00);
    bus_if.cs1 = 1'b1; bus_if.bus_en = 1'b0; bus_if.din = '0; bus_if.cmd_ack = 1'b0;
    bus_if.rsp_len = '0; bus_if.rd_valid = 1'b0; bus_if.rd_data = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_state",
        {bus_if.cmd_out != 64'd0, bus_if.cmd_valid, bus_if.rd_pop, bus_if.dout != 8'd0,
         bus_if.dout_oe, bus_if.busy, bus_if.xfer_done, bus_if.xfer_abort, bus_if.underrun},
        64'd0);
    rst = 1'b0;
    step();

    xfer(8, 1'b1, 4,    100, -1, -1, -1, 1'b0);  // 00..07 command, 4 clean bytes
    xfer(8, 1'b0, 4,    100,  2, -1, -1, 1'b0);  // 3rd byte missing
    xfer(5, 1'b0, 0,    100, -1, -1, -1, 1'b0);  // abort mid-command
    xfer(8, 1'b1, 3,    100, -1, -1, -1, 1'b0);
    xfer(8, 1'b0, 0,    100, -1, -1, -1, 1'b0);  // empty response
    xfer(8, 1'b0, 1,     50, -1, -1, -1, 1'b0);
    xfer(8, 1'b0, 5000,  90, -1, -1, -1, 1'b0);  // clamped to 4096
    xfer(8, 1'b0, 6,    100, -1, -2, -1, 1'b0);  // abort while waiting for ack
    xfer(8, 1'b0, 10,    70, -1,  4, -1, 1'b0);  // abort mid-data
`ifdef NTR_SEQ_TIMEOUT_EN
    xfer(8, 1'b0, 0,    100, -1, -1, -1, 1'b1);  // no ack -> timeout
    xfer(8, 1'b0, 3,    100, -1, -1, -1, 1'b0);
`endif
    for (int t = 0; t < 25; t++) begin
      n   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8;
      len = $urandom_range(0, 24);
      r   = $urandom_range(0, 9);
      ab  = -1;
      if (r == 0) ab = -2;
      else if (r == 1 && len > 0) ab = $urandom_range(0, len - 1);
      xfer(n, 1'b0, len, $urandom_range(40, 100), -1, ab, -1, 1'b0);
    end
    xfer(8, 1'b0, 10, 100, -1, -1, 3, 1'b0);     // reset mid-data
    xfer(8, 1'b1, 2,  100, -1, -1, -1, 1'b0);

    bus_if.cs1 = 1'b1; bus_if.bus_en = 1'b0;
    repeat (4) step();
    chk("bytes_left", 64'(byteq.size()), 64'd0);
    chk("cmds_left", 64'(cmdq.size()), 64'd0);
    chk("events_left", 64'(evq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
